// File: rtl/cordic_req_scheduler.sv
// cordic_req_scheduler: round-robin front end sharing one iterative CORDIC
// sin/cos engine among NUM_REQ clients, one transaction in flight at a time.
// Optional engine watchdog: define CORDIC_SCHED_TIMEOUT_EN.
module cordic_req_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ANGLE_W = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ANGLE_W-1:0]    req_angle,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_W-1:0]             rsp_sin,
  output logic [DATA_W-1:0]             rsp_cos,
  output logic                          rsp_err,
  output logic                          eng_start,
  output logic [ANGLE_W-1:0]            eng_angle,
  input  logic                          eng_done,
  input  logic [DATA_W-1:0]             eng_sin,
  input  logic [DATA_W-1:0]             eng_cos,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ANGLE_W-1:0]  angle_q, angle_d;
  logic [DATA_W-1:0]   sin_q, sin_d;
  logic [DATA_W-1:0]   cos_q, cos_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic                eng_start_q, eng_start_d;
  logic                busy_q, busy_d;

  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx;
  int unsigned         cand;
  logic [ANGLE_W-1:0]  angle_arr [NUM_REQ];

`ifdef CORDIC_SCHED_TIMEOUT_EN
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                rsp_err_q, rsp_err_d;
  logic                timeout_hit;
`endif

  // Unpack the flat angle bus into one entry per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_angle
    assign angle_arr[gi] = req_angle[gi*ANGLE_W +: ANGLE_W];
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_found && req_valid[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  // Accept pulse is combinational so the grant lands in the request cycle
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    angle_d     = angle_q;
    sin_d       = sin_q;
    cos_d       = cos_q;
    rsp_valid_d = rsp_valid_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err_q;
    timeout_hit = (wait_cnt_q == 8'(TIMEOUT - 1));
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          state_d    = ST_ISSUE;
          angle_d    = angle_arr[gnt_idx];
          grant_id_d = gnt_idx;
          rr_ptr_d   = gnt_idx;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef CORDIC_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_d     = ST_RESP;
          sin_d       = eng_sin;
          cos_d       = eng_cos;
          rsp_valid_d = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
`ifdef CORDIC_SCHED_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (timeout_hit) begin
          // Engine gave up on: report an error with zeroed data
          state_d     = ST_RESP;
          sin_d       = '0;
          cos_d       = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
        end else begin
          wait_cnt_d  = wait_cnt_q + 8'd1;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready[grant_id_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    eng_start_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      grant_id_q  <= '0;
      angle_q     <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      rsp_valid_q <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      angle_q     <= angle_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
      rsp_valid_q <= rsp_valid_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sin   = sin_q;
  assign rsp_cos   = cos_q;
  assign eng_start = eng_start_q;
  assign eng_angle = angle_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Directed bench for cordic_req_scheduler: a transaction table plus hand
// sequences for reset, spurious done, held round-robin and the watchdog.
module tb_cordic_req_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_angle;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [DW-1:0]     rsp_sin;
  logic [DW-1:0]     rsp_cos;
  logic              rsp_err;
  logic              eng_start;
  logic [AW-1:0]     eng_angle;
  logic              eng_done;
  logic [DW-1:0]     eng_sin;
  logic [DW-1:0]     eng_cos;
  logic              busy;
  logic [1:0]        grant_id;

  cordic_req_scheduler #(
    .NUM_REQ(NR), .ANGLE_W(AW), .DATA_W(DW), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_angle(eng_angle), .eng_done(eng_done),
    .eng_sin(eng_sin), .eng_cos(eng_cos),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [AW-1:0] ang [NR];

  // Count engine start pulses, sampled away from the active edge
  always @(negedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  typedef struct {
    logic [NR-1:0] reqv;
    int            lat;
    logic [DW-1:0] esin;
    logic [DW-1:0] ecos;
    int            exp_g;
    int            bp;
    bit            spur;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int g);
    oh = 4'(1) << g;
  endfunction

  // One full transaction; entered and left at negedge+1 with the DUT idle
  task automatic run_txn(input logic [NR-1:0] reqv, input int lat,
                         input logic [DW-1:0] es, input logic [DW-1:0] ec,
                         input int g, input int bp, input bit spur, input string tag);
    int s0;
    req_valid = reqv;
    rsp_ready = '1;
    eng_done  = 1'b0;
    #1;
    check({tag, ":req_ready"}, 32'(req_ready), 32'(oh(g)));
    s0 = start_cnt;
    @(negedge clk); #1;
    check({tag, ":eng_start"}, 32'(eng_start), 32'd1);
    check({tag, ":eng_angle"}, 32'(eng_angle), 32'(ang[g]));
    check({tag, ":grant_id"},  32'(grant_id),  32'(g));
    check({tag, ":busy"},      32'(busy),      32'd1);
    check({tag, ":no_ready"},  32'(req_ready), 32'd0);
    if (spur) begin
      eng_done = 1'b1; eng_sin = 16'h5555; eng_cos = 16'h5555;
    end
    if (bp > 0) rsp_ready = ~oh(g);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      eng_done = 1'b0; eng_sin = 16'hDEAD; eng_cos = 16'hDEAD;
      #1;
      check({tag, ":wait_no_rsp"}, 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    eng_done = 1'b1; eng_sin = es; eng_cos = ec;
    @(negedge clk);
    eng_done = 1'b0; eng_sin = 16'hBEEF; eng_cos = 16'hBEEF;
    #1;
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(oh(g)));
    check({tag, ":rsp_sin"},   32'(rsp_sin),   32'(es));
    check({tag, ":rsp_cos"},   32'(rsp_cos),   32'(ec));
    check({tag, ":rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, ":one_start"}, 32'(start_cnt - s0), 32'd1);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk); #1;
      check({tag, ":bp_valid"}, 32'(rsp_valid), 32'(oh(g)));
      check({tag, ":bp_sin"},   32'(rsp_sin),   32'(es));
      check({tag, ":bp_start"}, 32'(eng_start), 32'd0);
    end
    rsp_ready = '1;
    @(negedge clk); #1;
    check({tag, ":rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ":idle"},     32'(busy),      32'd0);
    check({tag, ":sin_hold"}, 32'(rsp_sin),   32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    ang[0] = 16'hF100; ang[1] = 16'h0F00; ang[2] = 16'h3C00; ang[3] = 16'h7A00;
    req_angle = {ang[3], ang[2], ang[1], ang[0]};
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    eng_done = 1'b0; eng_sin = '0; eng_cos = '0;

    // Transaction table: grant sequence follows round-robin from reset pointer 3
    vecs[0] = '{4'b0010, 16, 16'h0400, 16'h06ED, 1, 0,  1'b0};
    vecs[1] = '{4'b1111, 3,  16'h1234, 16'h0ABC, 2, 0,  1'b1};
    vecs[2] = '{4'b1111, 1,  16'h0111, 16'h0222, 3, 0,  1'b0};
    vecs[3] = '{4'b1111, 5,  16'h0333, 16'h0444, 0, 0,  1'b0};
    vecs[4] = '{4'b1111, 2,  16'h0555, 16'h0666, 1, 10, 1'b0};
    vecs[5] = '{4'b0001, 4,  16'h0777, 16'h0788, 0, 0,  1'b0};
    vecs[6] = '{4'b0001, 1,  16'h0799, 16'h07AA, 0, 0,  1'b0};
    vecs[7] = '{4'b1000, 7,  16'hF800, 16'hFC00, 3, 0,  1'b0};
    vecs[8] = '{4'b1010, 2,  16'h0100, 16'h0200, 1, 3,  1'b0};
    vecs[9] = '{4'b0101, 2,  16'h0300, 16'h0400, 2, 0,  1'b0};

    #1;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_grant_id",  32'(grant_id),  32'd0);
    check("rst_rsp_sin",   32'(rsp_sin),   32'd0);
    check("rst_rsp_cos",   32'(rsp_cos),   32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_eng_angle", 32'(eng_angle), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious done while idle
    eng_done = 1'b1; eng_sin = 16'h5555; eng_cos = 16'h5555;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("spur_idle_busy",  32'(busy),      32'd0);
    check("spur_idle_valid", 32'(rsp_valid), 32'd0);
    check("spur_idle_sin",   32'(rsp_sin),   32'd0);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].reqv, vecs[i].lat, vecs[i].esin, vecs[i].ecos,
              vecs[i].exp_g, vecs[i].bp, vecs[i].spur, $sformatf("vec%0d", i));
    end
    req_valid = '0;

    // Reset in the middle of WAIT drops the transaction
    req_valid = 4'b0100;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_eng_start", 32'(eng_start), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    eng_done = 1'b1; eng_sin = 16'h1111; eng_cos = 16'h2222;
    @(negedge clk);
    eng_done = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_rsp",  32'(rsp_valid), 32'd0);
    check("midrst_idle",    32'(busy),      32'd0);
    check("midrst_sin_clr", 32'(rsp_sin),   32'd0);

    // Held all-request round-robin from reset: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 2, 16'(16'h0A00 + i), 16'(16'h0B00 + i), i % 4, 0, 1'b0,
              $sformatf("rr%0d", i));
    end
    req_valid = '0;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    // Engine never finishes: watchdog answers with an error
    rsp_ready = '1;
    req_valid = 4'b0001;
    @(negedge clk); #1;
    check("to_start", 32'(eng_start), 32'd1);
    req_valid = '0;
    n = 0;
    while (rsp_valid == '0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("to_latency", 32'(n),         32'd65);
    check("to_valid",   32'(rsp_valid), 32'(oh(0)));
    check("to_err",     32'(rsp_err),   32'd1);
    check("to_sin",     32'(rsp_sin),   32'd0);
    check("to_cos",     32'(rsp_cos),   32'd0);
    @(negedge clk);
    eng_done = 1'b1; eng_sin = 16'h7777; eng_cos = 16'h7777;
    @(negedge clk);
    eng_done = 1'b0;
    #1;
    check("to_late_busy",  32'(busy),      32'd0);
    check("to_late_valid", 32'(rsp_valid), 32'd0);
`else
    // Without the watchdog WAIT never ends on its own
    n = 0;
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    repeat (200) @(negedge clk);
    #1;
    check("nto_busy",  32'(busy),      32'd1);
    check("nto_valid", 32'(rsp_valid), 32'd0);
    check("nto_err",   32'(rsp_err),   32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("nto_reset_idle", 32'(busy), 32'(n));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
